// File: rtl/data_bus_responder.sv
`default_nettype none
// data_bus_responder: wait-state memory responder for the rv32i data port with a byte-writable word store.
// Optional host mailbox enabled by macro DATA_BUS_RESPONDER_TOHOST_EN.
module data_bus_responder #(
    parameter int          DEPTH       = 1024,
    parameter int          WAIT_STATES = 2,
    parameter logic [31:0] TOHOST_ADDR = 32'h0000_FFF0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_address,
    input  logic        data_read_enable,
    output logic [31:0] data_read_data,
    output logic        data_read_rdy,
    input  logic        data_write_enable,
    input  logic [3:0]  data_write_byte_enable,
    input  logic [31:0] data_write_data,
    output logic        data_write_rdy,
    output logic        busy,
`ifdef DATA_BUS_RESPONDER_TOHOST_EN
    output logic [31:0] tohost_data,
    output logic        tohost_valid,
`endif
    output logic        bus_error
);

    localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [32:0] LIMIT     = 33'(DEPTH) << 2;
    localparam logic [3:0]  LAST_CNT  = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
`ifdef DATA_BUS_RESPONDER_TOHOST_EN
    localparam bit          TOHOST_EN = 1'b1;
`else
    localparam bit          TOHOST_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [3:0]  wait_cnt, wait_cnt_next;
    logic        capture;

    logic [31:0] addr_q, wdata_q, read_data;
    logic [3:0]  be_q;
    logic        wr_q, conflict_q;

    logic [31:0] mem [DEPTH];

    // With zero wait states the ACK is entered on the capture edge itself, so the
    // transaction must be decoded from the live inputs while still in IDLE.
    logic [31:0] op_addr, op_wdata, read_word;
    logic [3:0]  op_be;
    logic        op_write, op_conflict;
    logic        enter_ack, is_tohost, in_range, store_we, err_event;
    logic [AW-1:0] word_idx;

    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        capture       = 1'b0;
        case (state)
            ST_IDLE: begin
                wait_cnt_next = 4'd0;
                if (data_read_enable || data_write_enable) begin
                    capture    = 1'b1;
                    state_next = (WAIT_STATES > 0) ? ST_WAIT : ST_ACK;
                end
            end
            ST_WAIT: begin
                if (wait_cnt == LAST_CNT) begin
                    wait_cnt_next = 4'd0;
                    state_next    = ST_ACK;
                end else begin
                    wait_cnt_next = wait_cnt + 4'd1;
                end
            end
            ST_ACK:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        if (state == ST_IDLE) begin
            op_addr     = data_address;
            op_wdata    = data_write_data;
            op_be       = data_write_byte_enable;
            op_write    = data_write_enable;
            op_conflict = data_write_enable && data_read_enable;
        end else begin
            op_addr     = addr_q;
            op_wdata    = wdata_q;
            op_be       = be_q;
            op_write    = wr_q;
            op_conflict = conflict_q;
        end
    end

    assign enter_ack = (state_next == ST_ACK) && (state != ST_ACK);
    assign is_tohost = TOHOST_EN && (op_addr[31:2] == TOHOST_ADDR[31:2]);
    assign in_range  = !is_tohost && ({1'b0, op_addr} < LIMIT);
    assign word_idx  = op_addr[AW+1:2];
    assign store_we  = enter_ack && op_write && in_range && !rst;
    assign err_event = op_conflict || (!in_range && !is_tohost);

`ifdef DATA_BUS_RESPONDER_TOHOST_EN
    assign read_word = is_tohost ? tohost_data : (in_range ? mem[word_idx] : 32'h0);
`else
    assign read_word = in_range ? mem[word_idx] : 32'h0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            wait_cnt   <= 4'd0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            be_q       <= 4'h0;
            wr_q       <= 1'b0;
            conflict_q <= 1'b0;
            read_data  <= 32'h0;
            bus_error  <= 1'b0;
`ifdef DATA_BUS_RESPONDER_TOHOST_EN
            tohost_data  <= 32'h0;
            tohost_valid <= 1'b0;
`endif
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            if (capture) begin
                addr_q     <= data_address;
                wdata_q    <= data_write_data;
                be_q       <= data_write_byte_enable;
                wr_q       <= data_write_enable;
                conflict_q <= data_write_enable && data_read_enable;
            end
            if (enter_ack && !op_write) begin
                read_data <= read_word;
            end
            if (enter_ack && err_event) begin
                bus_error <= 1'b1;
            end
`ifdef DATA_BUS_RESPONDER_TOHOST_EN
            if (enter_ack && op_write && is_tohost) begin
                tohost_data  <= op_wdata;
                tohost_valid <= 1'b1;
            end
`endif
        end
    end

    // The store is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (store_we) begin
            for (int b = 0; b < 4; b++) begin
                if (op_be[b]) begin
                    mem[word_idx][8*b +: 8] <= op_wdata[8*b +: 8];
                end
            end
        end
    end

    assign data_read_data = read_data;
    assign data_read_rdy  = (state == ST_ACK) && !wr_q;
    assign data_write_rdy = (state == ST_ACK) && wr_q;
    assign busy           = (state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_data_bus_responder.sv
`default_nettype none
// tb_data_bus_responder: two responders (2 and 0 wait states) driven by random and directed
// transactions, checked against a word-array model of the bus rules.
module tb_data_bus_responder;

    localparam int          DEPTH  = 64;
    localparam logic [31:0] LIMIT  = 32'(DEPTH * 4);
    localparam logic [31:0] TOHOST = 32'h0000_FFF0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_en [2];
    logic        wr_en [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [3:0]  be    [2];
    logic [31:0] rdata [2];
    logic        rrdy  [2];
    logic        wrdy  [2];
    logic        busy  [2];
    logic        berr  [2];
`ifdef DATA_BUS_RESPONDER_TOHOST_EN
    logic [31:0] th_data  [2];
    logic        th_valid [2];
    logic [31:0] m_th_data  [2];
    logic        m_th_valid [2];
`endif

    logic [31:0] m_mem [2][DEPTH];
    logic        m_err [2];
    logic [31:0] m_rd  [2];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        data_bus_responder #(
            .DEPTH       (DEPTH),
            .WAIT_STATES ((g == 0) ? 2 : 0),
            .TOHOST_ADDR (TOHOST)
        ) u_dut (
            .clk                    (clk),
            .rst                    (rst),
            .data_address           (addr[g]),
            .data_read_enable       (rd_en[g]),
            .data_read_data         (rdata[g]),
            .data_read_rdy          (rrdy[g]),
            .data_write_enable      (wr_en[g]),
            .data_write_byte_enable (be[g]),
            .data_write_data        (wdata[g]),
            .data_write_rdy         (wrdy[g]),
            .busy                   (busy[g]),
`ifdef DATA_BUS_RESPONDER_TOHOST_EN
            .tohost_data            (th_data[g]),
            .tohost_valid           (th_valid[g]),
`endif
            .bus_error              (berr[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int ws_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_err[d] = 1'b0;
            m_rd[d]  = 32'h0;
`ifdef DATA_BUS_RESPONDER_TOHOST_EN
            m_th_data[d]  = 32'h0;
            m_th_valid[d] = 1'b0;
`endif
        end
    endtask

    // One complete request/acknowledge handshake on responder d, with model update.
    task automatic txn(input int d, input bit rd, input bit wr, input logic [31:0] a,
                       input logic [3:0] m, input logic [31:0] w);
        int  lat;
        bit  oor, th;
        @(negedge clk);
        rd_en[d] = rd; wr_en[d] = wr; addr[d] = a; be[d] = m; wdata[d] = w;
        @(posedge clk);
        lat = 0;
        for (int n = 1; n <= 20 && lat == 0; n++) begin
            @(negedge clk);
            check("busy_during", 32'(busy[d]), 32'd1);
            if (rrdy[d] || wrdy[d]) lat = n;
        end
        check("latency", 32'(lat), 32'(ws_of(d) + 1));
        check("rdy_kind", {30'd0, rrdy[d], wrdy[d]}, wr ? 32'd1 : 32'd2);
        th = 1'b0;
`ifdef DATA_BUS_RESPONDER_TOHOST_EN
        th = (a[31:2] == TOHOST[31:2]);
`endif
        oor = !th && (a >= LIMIT);
        if (wr) begin
            if (rd || oor) m_err[d] = 1'b1;
`ifdef DATA_BUS_RESPONDER_TOHOST_EN
            if (th) begin
                m_th_data[d]  = w;
                m_th_valid[d] = 1'b1;
            end
`endif
            if (!oor && !th) begin
                for (int b = 0; b < 4; b++)
                    if (m[b]) m_mem[d][a[31:2] % DEPTH][8*b +: 8] = w[8*b +: 8];
            end
        end else begin
            if (oor) begin
                m_err[d] = 1'b1;
                m_rd[d]  = 32'h0;
            end else if (th) begin
`ifdef DATA_BUS_RESPONDER_TOHOST_EN
                m_rd[d] = m_th_data[d];
`endif
            end else begin
                m_rd[d] = m_mem[d][a[31:2] % DEPTH];
            end
        end
        check("read_data", rdata[d], m_rd[d]);
        check("bus_error", 32'(berr[d]), 32'(m_err[d]));
`ifdef DATA_BUS_RESPONDER_TOHOST_EN
        check("tohost_data", th_data[d], m_th_data[d]);
        check("tohost_valid", 32'(th_valid[d]), 32'(m_th_valid[d]));
`endif
        rd_en[d] = 1'b0; wr_en[d] = 1'b0;
        @(negedge clk);
        check("busy_after", 32'(busy[d]), 32'd0);
        check("rdy_after", {30'd0, rrdy[d], wrdy[d]}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [31:0] a;
        int          sel;
        for (int d = 0; d < 2; d++) begin
            rd_en[d] = 1'b0; wr_en[d] = 1'b0; addr[d] = '0; be[d] = '0; wdata[d] = '0;
        end
        model_reset();
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rst_rrdy", 32'(rrdy[d]), 32'd0);
            check("rst_wrdy", 32'(wrdy[d]), 32'd0);
            check("rst_busy", 32'(busy[d]), 32'd0);
            check("rst_berr", 32'(berr[d]), 32'd0);
            check("rst_rdata", rdata[d], 32'd0);
        end
        rst = 1'b0;

        for (int d = 0; d < 2; d++)
            for (int i = 0; i < DEPTH; i++)
                txn(d, 1'b0, 1'b1, 32'(i * 4), 4'hF, $urandom);

        // Directed patterns on the two-wait-state responder.
        txn(0, 1'b0, 1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF);
        txn(0, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
        check("deadbeef", rdata[0], 32'hDEAD_BEEF);
        txn(0, 1'b0, 1'b1, 32'h20, 4'hF, 32'h1122_3344);
        txn(0, 1'b0, 1'b1, 32'h20, 4'b0101, 32'hAABB_CCDD);
        txn(0, 1'b1, 1'b0, 32'h22, 4'h0, 32'h0);
        check("byte_mask", rdata[0], 32'h11BB_33DD);
        txn(0, 1'b0, 1'b1, 32'h20, 4'h0, 32'hFFFF_FFFF);
        txn(0, 1'b1, 1'b0, 32'h20, 4'h0, 32'h0);
        check("be_zero", rdata[0], 32'h11BB_33DD);

        // Zero wait states: held read enable gives two acks two cycles apart.
        @(negedge clk);
        rd_en[1] = 1'b1; addr[1] = 32'h0;
        @(negedge clk);
        check("b2b_rdy1", 32'(rrdy[1]), 32'd1);
        check("b2b_data0", rdata[1], m_mem[1][0]);
        addr[1] = 32'h4;
        @(negedge clk);
        check("b2b_gap_rdy", 32'(rrdy[1]), 32'd0);
        check("b2b_gap_busy", 32'(busy[1]), 32'd0);
        @(negedge clk);
        check("b2b_rdy2", 32'(rrdy[1]), 32'd1);
        check("b2b_busy2", 32'(busy[1]), 32'd1);
        check("b2b_data1", rdata[1], m_mem[1][1]);
        m_rd[1] = m_mem[1][1];
        rd_en[1] = 1'b0;
        @(negedge clk);
        check("b2b_idle", 32'(busy[1]), 32'd0);

        // Out-of-range read sets the sticky error.
        txn(0, 1'b1, 1'b0, LIMIT, 4'h0, 32'h0);
        check("oor_data", rdata[0], 32'h0);
        check("oor_err", 32'(berr[0]), 32'd1);
        txn(0, 1'b0, 1'b1, 32'h8, 4'hF, 32'h5);
        txn(0, 1'b1, 1'b0, 32'h8, 4'h0, 32'h0);
        check("err_sticky", 32'(berr[0]), 32'd1);

        // Reset during WAIT of a write drops it.
        @(negedge clk);
        wr_en[0] = 1'b1; addr[0] = 32'h8; be[0] = 4'hF; wdata[0] = 32'h7777_7777;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_rrdy", 32'(rrdy[0]), 32'd0);
        check("abort_wrdy", 32'(wrdy[0]), 32'd0);
        check("abort_busy", 32'(busy[0]), 32'd0);
        check("abort_berr", 32'(berr[0]), 32'd0);
        check("abort_rdata", rdata[0], 32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        check("abort_hold_wrdy", 32'(wrdy[0]), 32'd0);
        wr_en[0] = 1'b0;
        rst = 1'b0;
        txn(0, 1'b1, 1'b0, 32'h8, 4'h0, 32'h0);
        check("abort_kept", rdata[0], 32'h5);

`ifdef DATA_BUS_RESPONDER_TOHOST_EN
        txn(0, 1'b0, 1'b1, TOHOST, 4'h0, 32'h1);
        check("th_valid", 32'(th_valid[0]), 32'd1);
        check("th_data", th_data[0], 32'h1);
        check("th_err", 32'(berr[0]), 32'd0);
        txn(0, 1'b1, 1'b0, TOHOST, 4'h0, 32'h0);
        check("th_read", rdata[0], 32'h1);
`endif

        for (int i = 0; i < 120; i++) begin
            int d;
            d   = i % 2;
            sel = $urandom_range(0, 19);
            if (sel == 0) a = LIMIT + 32'($urandom_range(0, 4095));
            else if (sel == 1) a = $urandom;
            else a = 32'($urandom_range(0, DEPTH * 4 - 1));
            if (sel == 2)
                txn(d, 1'b1, 1'b1, a, 4'($urandom), $urandom);
            else if (sel < 11)
                txn(d, 1'b0, 1'b1, a, 4'($urandom), $urandom);
            else
                txn(d, 1'b1, 1'b0, a, 4'h0, 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
